// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall masks, branch/trap redirect
// sequencing with a one-cycle flush pulse, and a stall watchdog.
module pipe_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    input  logic        timeout_clr,
    output logic [5:0]  stalled,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] run_q, run_d;
    logic        blocked_s;

    assign blocked_s = stallreq_mem | stallreq_ex;

    // Stall mask: the deepest requesting stage freezes itself and everything upstream.
    always_comb begin
        stalled = 6'b000000;
        if (state_q == FLUSH) begin
            stalled = 6'b000000;
        end else if (stallreq_mem) begin
            stalled = 6'b011111;
        end else if (stallreq_ex) begin
            stalled = 6'b001111;
        end else if (stallreq_id) begin
            stalled = 6'b000111;
        end else if (stallreq_if) begin
            stalled = 6'b000011;
        end else begin
            stalled = 6'b000000;
        end
    end

    // Redirect FSM next state and captured target.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    target_d = trap_vector;
                    state_d  = blocked_s ? PEND : FLUSH;
                end else if (branch_req) begin
                    target_d = branch_target;
                    state_d  = blocked_s ? PEND : FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (trap_req) begin
                    target_d = trap_vector;
                end else begin
                    target_d = target_q;
                end
                state_d = blocked_s ? PEND : FLUSH;
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flush pulse and redirect PC are registered so they line up with the FLUSH state.
    always_comb begin
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        if (state_d == FLUSH) begin
            flush_d  = 1'b1;
            new_pc_d = target_d;
        end else begin
            flush_d  = 1'b0;
            new_pc_d = new_pc_q;
        end
    end

    // Stall statistics and watchdog; a new expiry beats a simultaneous clear.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = 16'd0;
        timeout_d   = timeout_q;
        if ((stalled != 6'b000000) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (stalled[0]) begin
            run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        end else begin
            run_d = 16'd0;
        end
        // Only the transition onto TIMEOUT fires, so a saturated counter cannot re-arm a cleared flag.
        if ((run_d == 16'(TIMEOUT)) && (run_q != run_d)) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= 32'd0;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
            run_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
        end
    end

    assign flush     = flush_q;
    assign new_pc    = new_pc_q;
    assign timeout   = timeout_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with TIMEOUT=4.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        branch_req, trap_req, timeout_clr;
    logic [31:0] branch_target, trap_vector;
    logic [5:0]  stalled;
    logic        flush, timeout;
    logic [31:0] new_pc, stall_cnt;

    int checks_r;
    int failures_r;

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_req(branch_req), .branch_target(branch_target),
        .trap_req(trap_req), .trap_vector(trap_vector),
        .timeout_clr(timeout_clr),
        .stalled(stalled), .flush(flush), .new_pc(new_pc),
        .timeout(timeout), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_r = 0;
        failures_r = 0;
        rst = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
        branch_req = 1'b0; trap_req = 1'b0; timeout_clr = 1'b0;
        branch_target = 32'd0; trap_vector = 32'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_val("rst_flush", {31'd0, flush}, 32'd0);
        check_val("rst_new_pc", new_pc, 32'd0);
        check_val("rst_timeout", {31'd0, timeout}, 32'd0);
        check_val("rst_stall_cnt", stall_cnt, 32'd0);
        check_val("rst_stalled", {26'd0, stalled}, 32'h0000_0000);

        // Stall priority (combinational, no clock edges taken)
        stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
        check_val("prio_mem_id", {26'd0, stalled}, 32'h1F);
        stallreq_mem = 1'b0; #1;
        check_val("prio_id", {26'd0, stalled}, 32'h07);
        stallreq_ex = 1'b1; #1;
        check_val("prio_ex", {26'd0, stalled}, 32'h0F);
        stallreq_ex = 1'b0; stallreq_id = 1'b0; stallreq_if = 1'b1; #1;
        check_val("prio_if", {26'd0, stalled}, 32'h03);
        stallreq_if = 1'b0; #1;
        check_val("prio_none", {26'd0, stalled}, 32'h00);

        // Unblocked branch: flush in n+1; requests during FLUSH are ignored
        branch_req = 1'b1; branch_target = 32'h8000_0040;
        tick();
        branch_target = 32'h1234_5678; stallreq_if = 1'b1; #1;
        check_val("br_flush", {31'd0, flush}, 32'd1);
        check_val("br_new_pc", new_pc, 32'h8000_0040);
        check_val("br_stalled_forced", {26'd0, stalled}, 32'h00);
        tick();
        branch_req = 1'b0; stallreq_if = 1'b0; #1;
        check_val("br_flush_end", {31'd0, flush}, 32'd0);
        check_val("br_new_pc_hold", new_pc, 32'h8000_0040);
        check_val("br_no_count_in_flush", stall_cnt, 32'd0);
        tick();
        check_val("br_ignored_in_flush", {31'd0, flush}, 32'd0);

        // Trap beats branch in the same cycle
        branch_req = 1'b1; branch_target = 32'h0000_0AAA;
        trap_req = 1'b1; trap_vector = 32'h0000_0BBB;
        tick();
        branch_req = 1'b0; trap_req = 1'b0;
        check_val("trap_prio_flush", {31'd0, flush}, 32'd1);
        check_val("trap_prio_pc", new_pc, 32'h0000_0BBB);
        tick();

        // Deferred redirect with trap replacing target in PEND
        branch_req = 1'b1; branch_target = 32'h0000_0100; stallreq_mem = 1'b1;
        tick();
        branch_req = 1'b0;
        check_val("def_c2_flush", {31'd0, flush}, 32'd0);
        tick();
        trap_req = 1'b1; trap_vector = 32'h0000_0200;
        check_val("def_c3_flush", {31'd0, flush}, 32'd0);
        tick();
        trap_req = 1'b0; stallreq_mem = 1'b0;
        check_val("def_release_flush", {31'd0, flush}, 32'd0);
        check_val("def_stall_cnt", stall_cnt, 32'd3);
        tick();
        check_val("def_flush", {31'd0, flush}, 32'd1);
        check_val("def_new_pc", new_pc, 32'h0000_0200);
        tick();
        check_val("def_flush_once", {31'd0, flush}, 32'd0);

        // Reset during PEND discards the redirect
        branch_req = 1'b1; branch_target = 32'h0000_0300; stallreq_mem = 1'b1;
        tick();
        branch_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; stallreq_mem = 1'b0; #1;
        check_val("rstp_flush", {31'd0, flush}, 32'd0);
        check_val("rstp_stall_cnt", stall_cnt, 32'd0);
        check_val("rstp_timeout", {31'd0, timeout}, 32'd0);
        check_val("rstp_new_pc", new_pc, 32'd0);
        tick();
        check_val("rstp_no_flush", {31'd0, flush}, 32'd0);

        // Watchdog: four stalled cycles fire it
        stallreq_if = 1'b1;
        tick(); tick(); tick();
        check_val("wd_not_yet", {31'd0, timeout}, 32'd0);
        tick();
        check_val("wd_fired", {31'd0, timeout}, 32'd1);
        check_val("wd_stall_cnt", stall_cnt, 32'd4);
        stallreq_if = 1'b0;
        tick();
        check_val("wd_sticky", {31'd0, timeout}, 32'd1);
        check_val("wd_cnt_hold", stall_cnt, 32'd4);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        check_val("wd_cleared", {31'd0, timeout}, 32'd0);

        // Set wins over a simultaneous clear
        stallreq_if = 1'b1;
        tick(); tick(); tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0; stallreq_if = 1'b0;
        check_val("wd_set_wins", {31'd0, timeout}, 32'd1);
        check_val("wd_stall_cnt2", stall_cnt, 32'd8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
